// File: rtl/uart_cmd_assembler_pkg.sv
// Shared constants and types for the UART byte-to-command assembler.
package uart_cmd_assembler_pkg;

  localparam int unsigned CMD_WIDTH         = 32;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned TMO_COUNT_W       = 8;
  localparam logic [7:0]  TIMEOUT_COUNT_MAX = 8'hFF;

  typedef enum logic {
    BYTE_ORDER_LSB_FIRST = 1'b0,
    BYTE_ORDER_MSB_FIRST = 1'b1
  } byte_order_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_ASSEMBLE = 1'b1
  } asm_state_e;

  // Byte lane (0 = bits [7:0]) that receives the idx-th byte of a word.
  function automatic int unsigned byte_lane(input byte_order_e order,
                                            input int unsigned idx,
                                            input int unsigned bytes);
    return (order == BYTE_ORDER_MSB_FIRST) ? (bytes - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/uart_cmd_assembler_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty/level.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Push is refused when full, regardless of a pop in the same cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      full_q  <= (level_d == (AW+1)'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs UART bytes into command words, buffers them in a small FIFO toward
// cmd_axis, and discards a stalled partial word after an inter-byte timeout.
module uart_cmd_assembler
  import uart_cmd_assembler_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = CMD_WIDTH / BYTE_W,
  parameter bit          MSB_FIRST      = 1'b1,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic                            clk,
  input  logic                            reset_i,
  input  logic                            byte_valid_i,
  output logic                            byte_ready_o,
  input  logic [7:0]                      byte_data_i,
  input  logic                            resync_i,
  output logic                            cmd_axis_tvalid_o,
  input  logic                            cmd_axis_tready_i,
  output logic [8*BYTES_PER_WORD-1:0]     cmd_axis_tdata_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            partial_o,
  output logic                            timeout_pulse_o,
  output logic [TMO_COUNT_W-1:0]          timeout_count_o
);

  localparam int unsigned DATA_W   = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned CNT_W    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0) && (BYTES_PER_WORD > 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam byte_order_e ORDER    = MSB_FIRST ? BYTE_ORDER_MSB_FIRST : BYTE_ORDER_LSB_FIRST;

  asm_state_e             state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_W-1:0]      word_q, word_d;
  logic [TMO_W-1:0]       idle_q, idle_d;
  logic                   tmo_pulse_q, tmo_pulse_d;
  logic [TMO_COUNT_W-1:0] tmo_count_q, tmo_count_d;

  logic                   fifo_full, fifo_empty;
  logic                   push;
  logic [DATA_W-1:0]      push_data;
  logic [DATA_W-1:0]      word_with_byte;
  logic                   last_slot;
  logic                   byte_accept;

  assign last_slot    = (count_q == LAST_IDX);
  assign byte_ready_o = reset_i && !resync_i && !(last_slot && fifo_full);
  assign byte_accept  = byte_valid_i && byte_ready_o;

  // Current partial word with the incoming byte dropped into its lane.
  always_comb begin
    word_with_byte = word_q;
    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
      if (count_q == CNT_W'(k)) begin
        word_with_byte[byte_lane(ORDER, k, BYTES_PER_WORD)*BYTE_W +: BYTE_W] = byte_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      word_q      <= '0;
      idle_q      <= '0;
      tmo_pulse_q <= 1'b0;
      tmo_count_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_q      <= word_d;
      idle_q      <= idle_d;
      tmo_pulse_q <= tmo_pulse_d;
      tmo_count_q <= tmo_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_d      = word_q;
    idle_d      = idle_q;
    tmo_pulse_d = 1'b0;
    tmo_count_d = tmo_count_q;
    push        = 1'b0;
    push_data   = word_q;

    unique case (state_q)
      ST_IDLE: begin
        idle_d = '0;
        if (byte_accept) begin
          if (last_slot) begin
            push      = 1'b1;
            push_data = word_with_byte;
            count_d   = '0;
          end else begin
            word_d  = word_with_byte;
            count_d = count_q + CNT_W'(1);
            state_d = ST_ASSEMBLE;
          end
        end
      end
      ST_ASSEMBLE: begin
        if (resync_i) begin
          count_d = '0;
          idle_d  = '0;
          state_d = ST_IDLE;
        end else if (byte_accept) begin
          idle_d = '0;
          if (last_slot) begin
            push      = 1'b1;
            push_data = word_with_byte;
            count_d   = '0;
            state_d   = ST_IDLE;
          end else begin
            word_d  = word_with_byte;
            count_d = count_q + CNT_W'(1);
          end
        end else if (byte_valid_i) begin
          // Held off by a full FIFO: not idle, so the counter holds.
          idle_d = idle_q;
        end else if (TMO_EN) begin
          if (idle_q == TMO_LAST) begin
            count_d     = '0;
            idle_d      = '0;
            state_d     = ST_IDLE;
            tmo_pulse_d = 1'b1;
            if (tmo_count_q != TIMEOUT_COUNT_MAX) tmo_count_d = tmo_count_q + TMO_COUNT_W'(1);
          end else begin
            idle_d = idle_q + TMO_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        idle_d  = '0;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_ni     (reset_i),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (cmd_axis_tready_i),
    .pop_data_o (cmd_axis_tdata_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level_o)
  );

  assign cmd_axis_tvalid_o = !fifo_empty;
  assign partial_o         = (state_q == ST_ASSEMBLE);
  assign timeout_pulse_o   = tmo_pulse_q;
  assign timeout_count_o   = tmo_count_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard bench: dut_a is 4-byte MSB-first with a 100-cycle timeout,
// dut_b is 2-byte LSB-first with the timeout disabled.
module tb_uart_cmd_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;

  logic        a_valid, a_ready, a_resync, a_tvalid, a_tready, a_partial, a_pulse;
  logic [7:0]  a_data, a_tcount;
  logic [31:0] a_tdata;
  logic [2:0]  a_level;

  logic        b_valid, b_ready, b_resync, b_tvalid, b_tready, b_partial, b_pulse;
  logic [7:0]  b_data, b_tcount;
  logic [15:0] b_tdata;
  logic [2:0]  b_level;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  uart_cmd_assembler #(
    .BYTES_PER_WORD(4), .MSB_FIRST(1'b1), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)
  ) dut_a (
    .clk(clk), .reset_i(reset_n),
    .byte_valid_i(a_valid), .byte_ready_o(a_ready), .byte_data_i(a_data),
    .resync_i(a_resync),
    .cmd_axis_tvalid_o(a_tvalid), .cmd_axis_tready_i(a_tready), .cmd_axis_tdata_o(a_tdata),
    .fifo_level_o(a_level), .partial_o(a_partial),
    .timeout_pulse_o(a_pulse), .timeout_count_o(a_tcount)
  );

  uart_cmd_assembler #(
    .BYTES_PER_WORD(2), .MSB_FIRST(1'b0), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset_i(reset_n),
    .byte_valid_i(b_valid), .byte_ready_o(b_ready), .byte_data_i(b_data),
    .resync_i(b_resync),
    .cmd_axis_tvalid_o(b_tvalid), .cmd_axis_tready_i(b_tready), .cmd_axis_tdata_o(b_tdata),
    .fifo_level_o(b_level), .partial_o(b_partial),
    .timeout_pulse_o(b_pulse), .timeout_count_o(b_tcount)
  );

  // Output monitor for dut_a: every handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && a_tvalid === 1'b1 && a_tready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: unexpected word %h, no word required", a_tdata);
      end else begin
        if (a_tdata !== exp_q[0]) begin
          n_fail++;
          $display("FAIL scoreboard: got %h, required %h", a_tdata, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input bit sel, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    if (sel) begin b_valid = 1'b1; b_data = b; end
    else     begin a_valid = 1'b1; a_data = b; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = sel ? b_ready : a_ready;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_byte: byte %h got no ready in 50 cycles, required acceptance", b);
    end
  endtask

  task automatic send_word_a(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte(1'b0, w[8*(3-j) +: 8]);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0 || a_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s drain: %0d words pending tvalid=%b, required 0 pending tvalid=0",
               tag, exp_q.size(), a_tvalid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    a_valid = 1'b1; a_data = 8'h00; a_resync = 1'b0; a_tready = 1'b0;
    b_valid = 1'b1; b_data = 8'h00; b_resync = 1'b0; b_tready = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests += 8;
    if (a_ready !== 1'b0)   begin n_fail++; $display("FAIL reset a_ready: got %b required 0", a_ready); end
    if (b_ready !== 1'b0)   begin n_fail++; $display("FAIL reset b_ready: got %b required 0", b_ready); end
    if (a_tvalid !== 1'b0)  begin n_fail++; $display("FAIL reset tvalid: got %b required 0", a_tvalid); end
    if (a_tdata !== 32'h0)  begin n_fail++; $display("FAIL reset tdata: got %h required 0", a_tdata); end
    if (a_level !== 3'd0)   begin n_fail++; $display("FAIL reset level: got %0d required 0", a_level); end
    if (a_partial !== 1'b0) begin n_fail++; $display("FAIL reset partial: got %b required 0", a_partial); end
    if (a_pulse !== 1'b0)   begin n_fail++; $display("FAIL reset pulse: got %b required 0", a_pulse); end
    if (a_tcount !== 8'd0)  begin n_fail++; $display("FAIL reset tcount: got %0d required 0", a_tcount); end
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first();
    a_tready = 1'b1;
    send_byte(1'b0, 8'h12);
    send_byte(1'b0, 8'h34);
    send_byte(1'b0, 8'h56);
    n_tests += 2;
    if (a_partial !== 1'b1) begin n_fail++; $display("FAIL msb partial after 3 bytes: got %b required 1", a_partial); end
    if (a_tvalid !== 1'b0)  begin n_fail++; $display("FAIL msb tvalid after 3 bytes: got %b required 0", a_tvalid); end
    send_byte(1'b0, 8'h78);
    exp_q.push_back(32'h12345678);
    n_tests += 3;
    if (a_tvalid !== 1'b1)        begin n_fail++; $display("FAIL msb tvalid latency: got %b required 1", a_tvalid); end
    if (a_tdata !== 32'h12345678) begin n_fail++; $display("FAIL msb tdata: got %h required 12345678", a_tdata); end
    if (a_partial !== 1'b0)       begin n_fail++; $display("FAIL msb partial after word: got %b required 0", a_partial); end
    wait_drain("msb");
  endtask

  task automatic test_lsb_first();
    b_tready = 1'b0;
    send_byte(1'b1, 8'hAA);
    send_byte(1'b1, 8'h55);
    n_tests += 3;
    if (b_tvalid !== 1'b1)     begin n_fail++; $display("FAIL lsb tvalid: got %b required 1", b_tvalid); end
    if (b_tdata !== 16'h55AA)  begin n_fail++; $display("FAIL lsb tdata: got %h required 55aa", b_tdata); end
    if (b_level !== 3'd1)      begin n_fail++; $display("FAIL lsb level: got %0d required 1", b_level); end
    b_tready = 1'b1;
    @(posedge clk); #1;
    b_tready = 1'b0;
    n_tests += 2;
    if (b_tvalid !== 1'b0) begin n_fail++; $display("FAIL lsb tvalid after pop: got %b required 0", b_tvalid); end
    if (b_level !== 3'd0)  begin n_fail++; $display("FAIL lsb level after pop: got %0d required 0", b_level); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[5];
    bit ok;
    for (int i = 0; i < 5; i++)
      w[i] = {8'hC0 + 8'(i), 8'hD0 + 8'(i), 8'hE0 + 8'(i), 8'hF0 + 8'(i)};
    a_tready = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(w[i]);
    for (int i = 0; i < 4; i++) send_word_a(w[i]);
    for (int j = 0; j < 3; j++) send_byte(1'b0, w[4][8*(3-j) +: 8]);
    a_valid = 1'b1;
    a_data  = w[4][7:0];
    repeat (4) @(negedge clk);
    n_tests += 4;
    if (a_ready !== 1'b0)  begin n_fail++; $display("FAIL b2b ready on 20th byte: got %b required 0", a_ready); end
    if (a_level !== 3'd4)  begin n_fail++; $display("FAIL b2b level: got %0d required 4", a_level); end
    if (a_tdata !== w[0])  begin n_fail++; $display("FAIL b2b held tdata: got %h required %h", a_tdata, w[0]); end
    if (a_partial !== 1'b1) begin n_fail++; $display("FAIL b2b partial: got %b required 1", a_partial); end
    @(posedge clk); #1;
    a_tready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = a_ready;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b 20th byte: not accepted after drain, required acceptance"); end
    wait_drain("b2b");
  endtask

  task automatic test_timeout();
    int seen;
    a_tready = 1'b1;
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h02);
    seen = 0;
    for (int k = 1; k <= 200 && seen == 0; k++) begin
      @(negedge clk);
      if (a_pulse === 1'b1) seen = k;
    end
    n_tests += 3;
    if (seen < 95 || seen > 105) begin n_fail++; $display("FAIL timeout delay: pulse at idle cycle %0d, required about 100", seen); end
    if (a_partial !== 1'b0) begin n_fail++; $display("FAIL timeout partial: got %b required 0", a_partial); end
    if (a_tcount !== 8'd1)  begin n_fail++; $display("FAIL timeout count: got %0d required 1", a_tcount); end
    @(negedge clk);
    n_tests++;
    if (a_pulse !== 1'b0) begin n_fail++; $display("FAIL timeout pulse width: got %b next cycle, required 0", a_pulse); end
    @(posedge clk); #1;
    send_word_a(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    wait_drain("timeout");
  endtask

  task automatic test_stall_hold();
    logic [31:0] w[5];
    int events;
    bit ok;
    for (int i = 0; i < 5; i++)
      w[i] = {8'h30 + 8'(i), 8'h41 + 8'(i), 8'h52 + 8'(i), 8'h63 + 8'(i)};
    a_tready = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(w[i]);
    for (int i = 0; i < 4; i++) send_word_a(w[i]);
    for (int j = 0; j < 3; j++) send_byte(1'b0, w[4][8*(3-j) +: 8]);
    a_valid = 1'b1;
    a_data  = w[4][7:0];
    events = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (a_ready !== 1'b0 || a_pulse !== 1'b0) events++;
    end
    n_tests += 3;
    if (events != 0)        begin n_fail++; $display("FAIL stall hold: %0d cycles with ready or pulse high, required 0", events); end
    if (a_tcount !== 8'd1)  begin n_fail++; $display("FAIL stall tcount: got %0d required 1", a_tcount); end
    if (a_partial !== 1'b1) begin n_fail++; $display("FAIL stall partial: got %b required 1", a_partial); end
    @(posedge clk); #1;
    a_tready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = a_ready;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stall 4th byte: not accepted after drain, required acceptance"); end
    wait_drain("stall");
  endtask

  task automatic test_resync_reset();
    int pulses;
    a_tready = 1'b0;
    send_word_a(32'hA1B2C3D4);
    exp_q.push_back(32'hA1B2C3D4);
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    a_resync = 1'b1;
    a_valid  = 1'b1;
    a_data   = 8'h33;
    @(negedge clk);
    n_tests++;
    if (a_ready !== 1'b0) begin n_fail++; $display("FAIL resync ready: got %b required 0", a_ready); end
    @(posedge clk); #1;
    a_resync = 1'b0;
    a_valid  = 1'b0;
    n_tests += 4;
    if (a_partial !== 1'b0)       begin n_fail++; $display("FAIL resync partial: got %b required 0", a_partial); end
    if (a_level !== 3'd1)         begin n_fail++; $display("FAIL resync level: got %0d required 1", a_level); end
    if (a_tvalid !== 1'b1)        begin n_fail++; $display("FAIL resync tvalid: got %b required 1", a_tvalid); end
    if (a_tdata !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL resync tdata: got %h required a1b2c3d4", a_tdata); end
    pulses = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (a_pulse !== 1'b0) pulses++;
    end
    n_tests += 2;
    if (pulses != 0)       begin n_fail++; $display("FAIL resync pulse: %0d pulse cycles, required 0", pulses); end
    if (a_tcount !== 8'd1) begin n_fail++; $display("FAIL resync tcount: got %0d required 1", a_tcount); end
    @(posedge clk); #1;
    send_word_a(32'h0BADF00D);
    exp_q.push_back(32'h0BADF00D);
    send_byte(1'b0, 8'h44);
    a_tready = 1'b1;
    @(posedge clk); #2;
    n_tests++;
    if (a_level !== 3'd1) begin n_fail++; $display("FAIL drain level before reset: got %0d required 1", a_level); end
    #1 reset_n = 1'b0;
    #1;
    n_tests += 5;
    if (a_tvalid !== 1'b0)  begin n_fail++; $display("FAIL async reset tvalid: got %b required 0", a_tvalid); end
    if (a_level !== 3'd0)   begin n_fail++; $display("FAIL async reset level: got %0d required 0", a_level); end
    if (a_partial !== 1'b0) begin n_fail++; $display("FAIL async reset partial: got %b required 0", a_partial); end
    if (a_tcount !== 8'd0)  begin n_fail++; $display("FAIL async reset tcount: got %0d required 0", a_tcount); end
    if (a_tdata !== 32'h0)  begin n_fail++; $display("FAIL async reset tdata: got %h required 0", a_tdata); end
    exp_q.delete();
    a_tready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    a_tready = 1'b1;
    send_word_a(32'hCAFEF00D);
    exp_q.push_back(32'hCAFEF00D);
    wait_drain("post-reset");
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_timeout();
    test_stall_hold();
    test_resync_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
